// File: rtl/sr_cmd_sequencer.sv
// Command FIFO plus replay FSM that drives S/R into an SR flip-flop stage.
// Optional Q self-check is built only when SR_CHECK_EN is defined.
module sr_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    output logic             busy,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t         state, state_nxt;
    logic [1:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [TW-1:0]  timer, timer_nxt;
    logic           push, pop;
    logic [1:0]     head;
    logic           s_nxt, r_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cmd_ready = !rst && (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);

    // FIFO storage is data only; occupancy and pointers carry the reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Illegal 11 keeps its slot and hold time but is driven as 00.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pop       = 1'b0;
        s_nxt     = S;
        r_nxt     = R;
        case (state)
            IDLE: begin
                s_nxt = 1'b0;
                r_nxt = 1'b0;
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                    timer_nxt = TIMER_LOAD;
                    s_nxt     = (head == 2'b10);
                    r_nxt     = (head == 2'b01);
                end
            end
            DRIVE: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    timer_nxt = TIMER_LOAD;
                    s_nxt     = (head == 2'b10);
                    r_nxt     = (head == 2'b01);
                end else begin
                    state_nxt = IDLE;
                    s_nxt     = 1'b0;
                    r_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                s_nxt     = 1'b0;
                r_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            S           <= 1'b0;
            R           <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            S     <= s_nxt;
            R     <= r_nxt;
            if (pop && (head == 2'b11)) begin
                illegal_cnt <= sat_inc(illegal_cnt);
            end
        end
    end

`ifdef SR_CHECK_EN
    logic exp_q, chk_armed, mismatch_r;

    // exp_q tracks the FF using the same S/R the FF samples at each edge;
    // the first cycle after reset is skipped since Q may still be settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q      <= 1'b0;
            chk_armed  <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            chk_armed <= 1'b1;
            if (S)      exp_q <= 1'b1;
            else if (R) exp_q <= 1'b0;
            if (chk_armed && (q_fb != exp_q)) mismatch_r <= 1'b1;
        end
    end

    assign mismatch = mismatch_r;
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign mismatch    = 1'b0;
`endif

endmodule
